afe2256_lvds_word_aligner: RTL

Bit/word aligner and line framer that sits directly downstream of the AFE2256 ISERDES2 1:4 DDR deserializer. It accepts 4-bit deserialized groups and searches them for the 24-bit sync/deskew pattern (12'hFFF followed by 12'h000) at every bit offset. Once the pattern is found, the block locks the word boundary and emits 24-bit words split into a 12-bit pixel and a 12-bit alignment vector, with line markers, for the ROIC line buffer. The state register uses the package `deser_state_t` encoding (IDLE/ALIGN/SYNC/CAPTURE/ERROR).

---
 rtl/afe2256_lvds_word_aligner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/afe2256_lvds_word_aligner.sv
// Word aligner and line framer behind the AFE2256 ISERDES 1:4 deserializer.
// It finds the FFF000 sync pattern at any bit offset, locks the boundary and frames 24-bit words into lines.
package afe2256_lvds_word_aligner_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        SYNC    = 3'd2,
        CAPTURE = 3'd3,
        ERROR   = 3'd4
    } deser_state_t;
endpackage

module afe2256_lvds_word_aligner
    import afe2256_lvds_word_aligner_pkg::*;
#(
    parameter int SYNC_COUNT    = 4,
    parameter int ALIGN_TIMEOUT = 4096,
    parameter int LINE_PIXELS   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        resync,
    input  logic        in_valid,
    input  logic [3:0]  in_bits,
    output logic        out_valid,
    output logic [11:0] out_pixel,
    output logic [11:0] out_align,
    output logic        out_sol,
    output logic        out_eol,
    output logic        locked,
    output logic [1:0]  bit_offset,
    output logic [2:0]  state,
    output logic        align_err
);
    localparam logic [23:0] SYNC_WORD = 24'hFFF000;
    localparam int SW = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
    localparam int TW = (ALIGN_TIMEOUT > 1) ? $clog2(ALIGN_TIMEOUT) : 1;
    localparam int PW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_COUNT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(LINE_PIXELS - 1);

    deser_state_t  state_q, state_d;
    logic [26:0]   hist;
    logic [26:0]   nxt;
    logic [3:0]    match;
    logic [23:0]   word;
    logic [2:0]    ph, ph_d, ph_step;
    logic [SW-1:0] sync_cnt, sync_d;
    logic [TW-1:0] tmo_cnt, tmo_d;
    logic [PW-1:0] pix_cnt, pix_d;
    logic [1:0]    off_d;
    logic          boundary;
    logic          emit;

    // [3] of each group is the earliest bit, so the newest bit lands at nxt[0].
    assign nxt      = {hist[22:0], in_bits};
    assign word     = nxt[bit_offset +: 24];
    assign boundary = in_valid && (ph == 3'd5);
    assign ph_step  = (ph == 3'd5) ? 3'd0 : ph + 3'd1;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            match[k] = (nxt[k +: 24] == SYNC_WORD);
        end
    end

    // NOTE: every variable gets a default before any branch so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ph_d    = ph;
        sync_d  = sync_cnt;
        tmo_d   = tmo_cnt;
        pix_d   = pix_cnt;
        off_d   = bit_offset;
        emit    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            ph_d    = '0;
            sync_d  = '0;
            tmo_d   = '0;
            pix_d   = '0;
        end else if (resync && (state_q == SYNC || state_q == CAPTURE)) begin
            state_d = ALIGN;
            sync_d  = '0;
            tmo_d   = '0;
            pix_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ALIGN;
                    ph_d    = '0;
                    sync_d  = '0;
                    tmo_d   = '0;
                    pix_d   = '0;
                end
                ALIGN: begin
                    if (in_valid) begin
                        if (|match) begin
                            off_d   = match[0] ? 2'd0 : match[1] ? 2'd1 : match[2] ? 2'd2 : 2'd3;
                            ph_d    = '0;
                            sync_d  = SW'(1);
                            state_d = (SYNC_COUNT == 1) ? CAPTURE : SYNC;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state_d = ERROR;
                        end else begin
                            tmo_d = tmo_cnt + 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (in_valid) begin
                        ph_d = ph_step;
                        if (boundary) begin
                            if (word != SYNC_WORD) begin
                                state_d = ALIGN;
                                tmo_d   = '0;
                            end else if (sync_cnt == SYNC_LAST) begin
                                state_d = CAPTURE;
                            end else begin
                                sync_d = sync_cnt + 1'b1;
                            end
                        end
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        ph_d = ph_step;
                        if (boundary) begin
                            emit  = 1'b1;
                            pix_d = (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                        end
                    end
                end
                ERROR:   state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hist       <= '0;
            ph         <= '0;
            sync_cnt   <= '0;
            tmo_cnt    <= '0;
            pix_cnt    <= '0;
            bit_offset <= '0;
            out_valid  <= 1'b0;
            out_sol    <= 1'b0;
            out_eol    <= 1'b0;
            out_pixel  <= '0;
            out_align  <= '0;
        end else begin
            state_q    <= state_d;
            ph         <= ph_d;
            sync_cnt   <= sync_d;
            tmo_cnt    <= tmo_d;
            pix_cnt    <= pix_d;
            bit_offset <= off_d;
            if (in_valid) begin
                hist <= nxt;
            end
            out_valid <= emit;
            out_sol   <= emit && (pix_cnt == '0);
            out_eol   <= emit && (pix_cnt == PIX_LAST);
            // Data holds between strobes; only out_valid qualifies it.
            if (emit) begin
                out_pixel <= word[23:12];
                out_align <= word[11:0];
            end
        end
    end

    assign state     = state_q;
    assign locked    = (state_q == CAPTURE);
    assign align_err = (state_q == ERROR);

endmodule
